// File: rtl/ex_alu_stage.sv
// RV32I execute stage: combinational ALU feeding a one-entry registered EX/MEM slot.
// Define EX_ALU_FLAGS_EN to add registered carry/overflow/negative outputs.
module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [3:0]      alu_sel,
  input  logic [RD_W-1:0] rd_in,
  input  logic            wb_en_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            wb_en_out,
  output logic            zero
`ifdef EX_ALU_FLAGS_EN
  ,
  output logic            carry,
  output logic            overflow,
  output logic            negative
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110, ALU_SRA  = 4'b0111, ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001, ALU_PASS = 4'b1010
  } alu_op_e;

  // Shifter type codes shared with the rest of the core.
  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic              zero_q, zero_d;

  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   shift_res;
  logic [1:0]        sh_type;
  logic [4:0]        shamt;
  logic              accept;

  assign shamt = op_b[4:0];

  always_comb begin
    sh_type = SH_SRL;
    case (alu_sel)
      ALU_SLL: sh_type = SH_SLL;
      ALU_SRA: sh_type = SH_SRA;
      default: sh_type = SH_SRL;
    endcase
  end

  always_comb begin
    case (sh_type)
      SH_SLL:  shift_res = op_a << shamt;
      SH_SRA:  shift_res = $unsigned($signed(op_a) >>> shamt);
      SH_SRL:  shift_res = op_a >> shamt;
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    case (alu_sel)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = shift_res;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASS: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_ALU_FLAGS_EN
  logic [2:0]      flags_q, flags_d;
  logic [2:0]      flags_c;
  logic [XLEN:0]   add_ext;

  // Carry on SUB is NOT borrow, i.e. op_a >= op_b unsigned.
  always_comb begin
    add_ext    = {1'b0, op_a} + {1'b0, op_b};
    flags_c    = '0;
    flags_c[0] = alu_res[XLEN-1];
    case (alu_sel)
      ALU_ADD: begin
        flags_c[2] = add_ext[XLEN];
        flags_c[1] = (op_a[XLEN-1] == op_b[XLEN-1]) && (alu_res[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SUB: begin
        flags_c[2] = (op_a >= op_b);
        flags_c[1] = (op_a[XLEN-1] != op_b[XLEN-1]) && (alu_res[XLEN-1] != op_a[XLEN-1]);
      end
      default: ;
    endcase
  end

  assign carry    = flags_q[2];
  assign overflow = flags_q[1];
  assign negative = flags_q[0];
`endif

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
    wb_en_d  = wb_en_q;
    zero_d   = zero_q;
`ifdef EX_ALU_FLAGS_EN
    flags_d  = flags_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      wb_en_d = 1'b0;
    end else if (accept) begin
      state_d  = FULL;
      result_d = alu_res;
      rd_d     = rd_in;
      wb_en_d  = wb_en_in;
      zero_d   = (alu_res == '0);
`ifdef EX_ALU_FLAGS_EN
      flags_d  = flags_c;
`endif
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
      wb_en_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EMPTY;
      result_q <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef EX_ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      zero_q   <= zero_d;
`ifdef EX_ALU_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign result    = result_q;
  assign rd_out    = rd_q;
  assign wb_en_out = wb_en_q;
  assign zero      = zero_q;

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute stage of the pipelined RV32I core: takes ID/EX operands, computes the ALU result (routing shift ops through the existing shifter encoding), and holds the result in a registered EX/MEM output slot.
- Valid/ready handshake on both sides, plus flush from hazard control.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  ID/EX holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- flush  input  1  kill the instruction being accepted and the one held in the output slot.
- op_a  input  XLEN  operand A (rs1 or PC).
- op_b  input  XLEN  operand B (rs2 or immediate).
- alu_sel  input  4  operation select.
- rd_in  input  RD_W  destination register.
- wb_en_in  input  1  register-write enable.
- out_valid  output  1  EX/MEM slot holds a valid result.
- out_ready  input  1  MEM stage accepts this cycle.
- result  output  XLEN  registered ALU result.
- rd_out  output  RD_W  registered destination register.
- wb_en_out  output  1  registered write enable, gated by validity.
- zero  output  1  registered (result == 0).

Behaviour:
- alu_sel encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU, 1010 PASS_B.
  - 1011–1111 produce 0.
- Shifts: shamt = op_b[4:0]; op_b[31:5] ignored.
  - Shifter type code: SLL=01, SRL=00, SRA=10.
  - SRA fills with op_a[31]. SRL fills with 0.
- ADD/SUB wrap modulo 2^32.
- SLT/SLTU return 32'd1 or 32'd0.
- Combinational compute; result registered. Latency is 1 cycle from acceptance to out_valid.
- Accept condition: in_valid && in_ready. Define in_ready = !out_valid || out_ready.
- Each rising clk, in priority order:
  1. rst==0: out_valid=0, result=0, rd_out=0, wb_en_out=0, zero=0 (and flag outputs=0 if enabled). This holds even mid-stall.
  2. flush==1: out_valid=0 and wb_en_out=0. result, rd_out and zero may keep their old values. Any acceptance this cycle is discarded.
  3. Accept: load result, rd_out, zero and wb_en_out=wb_en_in; set out_valid=1.
  4. Slot drained (out_valid && out_ready && no accept): out_valid=0, wb_en_out=0.
  5. Stall (out_valid && !out_ready): all outputs held bit-exact.
- Simultaneous drain and accept (out_valid, out_ready, in_valid all 1): the new result replaces the old one with no bubble.
- wb_en_out is never 1 while out_valid is 0.
- Two-state control: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept, or on flush.
  - FULL→FULL on stall, or on drain with accept.
- rd_in==0 with wb_en_in==1 passes through unchanged; x0 suppression is the register file's job.

Optional Feature:
- Macro EX_ALU_FLAGS_EN.
- When defined, adds registered outputs carry, overflow and negative (1 bit each). They are loaded together with result and follow the same reset, flush-hold and stall rules.
  - ADD: carry = carry-out of bit 31.
  - SUB: carry = NOT borrow, i.e. op_a >= op_b unsigned.
  - overflow = signed overflow for ADD/SUB; 0 for all other ops.
  - negative = result[31] for every op.
- When undefined, these ports do not exist and no flag logic is generated.

Test Plan:
- Reset with rst=0 for 2 cycles while in_valid=1 → out_valid=0, result=0, wb_en_out=0. After release the first accept appears 1 cycle later.
- SRA op_a=0x80000010, op_b=0x00000024 (shamt=4) → result=0xF8000001. SRL with the same inputs → 0x08000001. SLL op_a=1, shamt=31 → 0x80000000.
- SUB op_a=5, op_b=5 → result=0, zero=1. SLT op_a=0xFFFFFFFF, op_b=1 → 1; SLTU with the same inputs → 0. With EX_ALU_FLAGS_EN: ADD 0x7FFFFFFF+1 → overflow=1, negative=1, carry=0.
- Back-to-back ADDs with out_ready=0 for 3 cycles → first result held bit-exact, in_ready=0. On out_ready=1 the second result loads the same cycle with no bubble.
- flush=1 asserted while FULL and in_valid=1 → next cycle out_valid=0, wb_en_out=0, and neither instruction appears.
- rst=0 asserted during a stall → next cycle all outputs are 0 regardless of out_ready.
